// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader
// Writer end of the configuration chain. It accepts configuration words on a
// valid/ready stream and shifts them MSB-first into the head of a CHAIN_LEN-flop
// chain. ccff_shift_en is high only on cycles that carry a real bit, so a stalled
// stream never clocks junk into the chain.
// Optional feature macro: CCFF_READBACK_EN. It adds capture of the old chain
// contents from ccff_tail and outputs them as rb_data/rb_valid.
//
// state  | meaning
// S_IDLE | waiting for start
// S_LOAD | cfg_ready high, waiting for a word
// S_SHIFT| one chain bit per cycle from shreg
// S_DONE | one-cycle done pulse, back to idle

module ccff_bitstream_loader #(
   parameter int CHAIN_LEN = 50,
   parameter int WORD_W    = 8,
   parameter int CNT_W     = 16
) (
   input  logic              prog_clk,
   input  logic              prog_reset,
   input  logic              start,
   input  logic [WORD_W-1:0] cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done
`ifdef CCFF_READBACK_EN
   ,
   output logic [WORD_W-1:0] rb_data,
   output logic              rb_valid
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] WORD_C      = CNT_W'(WORD_W);
   localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]  shreg_left_q, shreg_left_d;
   logic [CNT_W-1:0]  remaining;
   logic              last_bit;

   // Bits still owed to the chain; limits the final word to the chain tail.
   assign remaining = CHAIN_LEN_C - bit_cnt_q;
   assign last_bit  = ((bit_cnt_q + ONE_C) == CHAIN_LEN_C);

   // State and datapath registers.
   always_ff @(posedge prog_clk or posedge prog_reset) begin
      if (prog_reset) begin
         state_q      <= S_IDLE;
         bit_cnt_q    <= '0;
         shreg_q      <= '0;
         shreg_left_q <= '0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shreg_q      <= shreg_d;
         shreg_left_q <= shreg_left_d;
      end
   end

   // Next-state, shift datapath and outputs decoded from the current state.
   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      shreg_d       = shreg_q;
      shreg_left_d  = shreg_left_q;
      cfg_ready     = 1'b0;
      ccff_shift_en = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_LOAD;
               bit_cnt_d = '0;
            end
         end
         S_LOAD: begin
            busy      = 1'b1;
            cfg_ready = 1'b1;
            if (cfg_valid) begin
               shreg_d      = cfg_data;
               shreg_left_d = (remaining < WORD_C) ? remaining : WORD_C;
               state_d      = S_SHIFT;
            end
         end
         S_SHIFT: begin
            busy          = 1'b1;
            ccff_shift_en = 1'b1;
            shreg_d       = shreg_q << 1;
            shreg_left_d  = shreg_left_q - ONE_C;
            bit_cnt_d     = bit_cnt_q + ONE_C;
            if (shreg_left_q == ONE_C) begin
               state_d = last_bit ? S_DONE : S_LOAD;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Head bit is forced low whenever the chain is not being clocked.
   assign ccff_head = ccff_shift_en & shreg_q[WORD_W-1];

`ifdef CCFF_READBACK_EN
   localparam int RB_CW = $clog2(WORD_W) + 1;
   localparam logic [RB_CW-1:0] RB_WORD_C = RB_CW'(WORD_W);
   localparam logic [RB_CW-1:0] RB_ONE_C  = RB_CW'(1);

   logic [WORD_W-1:0] rb_shreg_q, rb_shreg_d;
   logic [RB_CW-1:0]  rb_cnt_q, rb_cnt_d;
   logic [WORD_W-1:0] rb_data_q, rb_data_d;
   logic              rb_valid_q, rb_valid_d;
   logic [WORD_W-1:0] rb_new;
   logic [RB_CW-1:0]  rb_cnt_new;

   assign rb_new     = {rb_shreg_q[WORD_W-2:0], ccff_tail};
   assign rb_cnt_new = rb_cnt_q + RB_ONE_C;

   // Readback capture registers.
   always_ff @(posedge prog_clk or posedge prog_reset) begin
      if (prog_reset) begin
         rb_shreg_q <= '0;
         rb_cnt_q   <= '0;
         rb_data_q  <= '0;
         rb_valid_q <= 1'b0;
      end else begin
         rb_shreg_q <= rb_shreg_d;
         rb_cnt_q   <= rb_cnt_d;
         rb_data_q  <= rb_data_d;
         rb_valid_q <= rb_valid_d;
      end
   end

   // Collect the tail bit on every chain clock; emit full words, and a
   // left-aligned partial word on the final bit of the load.
   always_comb begin
      rb_shreg_d = rb_shreg_q;
      rb_cnt_d   = rb_cnt_q;
      rb_data_d  = rb_data_q;
      rb_valid_d = 1'b0;
      if (state_q == S_IDLE && start) begin
         rb_shreg_d = '0;
         rb_cnt_d   = '0;
      end else if (ccff_shift_en) begin
         rb_shreg_d = rb_new;
         if (rb_cnt_new == RB_WORD_C) begin
            rb_valid_d = 1'b1;
            rb_data_d  = rb_new;
            rb_cnt_d   = '0;
         end else if (last_bit) begin
            rb_valid_d = 1'b1;
            rb_data_d  = rb_new << (RB_WORD_C - rb_cnt_new);
            rb_cnt_d   = '0;
         end else begin
            rb_cnt_d = rb_cnt_new;
         end
      end
   end

   assign rb_data  = rb_data_q;
   assign rb_valid = rb_valid_q;
`else
   logic unused_tail;
   assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader (default build, readback disabled).
// Expected chain bits are queued as words are driven and popped on every
// shift-enable cycle; a 50-flop chain model is compared at the end of each load.

module tb_ccff_bitstream_loader;

   localparam int CHAIN_LEN = 50;
   localparam int WORD_W    = 8;
   localparam int CNT_W     = 16;
   localparam int N_WORDS   = 7;
   localparam logic [55:0] FULL_STREAM = 56'hA53CFF00817EC0;

   logic              prog_clk = 1'b0;
   logic              prog_reset;
   logic              start;
   logic [WORD_W-1:0] cfg_data;
   logic              cfg_valid;
   logic              cfg_ready;
   logic              ccff_head;
   logic              ccff_shift_en;
   logic              ccff_tail;
   logic              busy;
   logic              done;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int shift_tot = 0;
   int done_tot  = 0;
   int done_cyc  = 0;
   bit exp_q[$];
   logic [CHAIN_LEN-1:0] chain_m = '0;
   logic [WORD_W-1:0] words [N_WORDS] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E, 8'hC0};

   ccff_bitstream_loader #(
      .CHAIN_LEN (CHAIN_LEN),
      .WORD_W    (WORD_W),
      .CNT_W     (CNT_W)
   ) dut (
      .prog_clk      (prog_clk),
      .prog_reset    (prog_reset),
      .start         (start),
      .cfg_data      (cfg_data),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .ccff_head     (ccff_head),
      .ccff_shift_en (ccff_shift_en),
      .ccff_tail     (ccff_tail),
      .busy          (busy),
      .done          (done)
   );

   always #5 prog_clk = ~prog_clk;

   always @(posedge prog_clk) cyc++;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Chain monitor: scoreboard pop per shifted bit, chain model, done tracking.
   always @(negedge prog_clk) begin
      bit e;
      if (ccff_shift_en) begin
         shift_tot++;
         if (exp_q.size() == 0) begin
            check_eq("sb_underflow", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check_eq("head_bit", ccff_head, e);
         end
         chain_m = {chain_m[CHAIN_LEN-2:0], ccff_head};
      end else begin
         check_eq("head_gated", ccff_head, 0);
      end
      if (done) begin
         done_tot++;
         done_cyc = cyc;
         check_eq("busy_at_done", busy, 0);
      end
   end

   task automatic push_word(input logic [WORD_W-1:0] w, inout int pushed);
      for (int b = WORD_W - 1; b >= 0; b--) begin
         if (pushed < CHAIN_LEN) begin
            exp_q.push_back(w[b]);
            pushed++;
         end
      end
   endtask

   task automatic wait_ready(output bit ok);
      int t;
      t = 0;
      while (!cfg_ready && t < 100) begin
         @(negedge prog_clk);
         t++;
      end
      ok = cfg_ready;
      if (!ok) check_eq("ready_timeout", 0, 1);
   endtask

   task automatic run_load(input int stall_idx, input int stall_len, input bit restart,
                           input int exp_lat);
      int base_sh, base_dn, start_cyc, pushed, t;
      bit ok;
      base_sh = shift_tot;
      base_dn = done_tot;
      pushed  = 0;
      @(posedge prog_clk); #1;
      start     = 1'b1;
      start_cyc = cyc;
      @(posedge prog_clk); #1;
      start = 1'b0;
      @(negedge prog_clk);
      check_eq("busy_after_start", busy, 1);
      for (int i = 0; i < N_WORDS; i++) begin
         cfg_data = words[i];
         if (i == stall_idx) begin
            cfg_valid = 1'b0;
            wait_ready(ok);
            if (!ok) return;
            repeat (stall_len) @(posedge prog_clk);
            #1;
            check_eq("shift_during_stall", ccff_shift_en, 0);
         end
         cfg_valid = 1'b1;
         wait_ready(ok);
         if (!ok) return;
         push_word(words[i], pushed);
         @(posedge prog_clk); #1;
         cfg_valid = 1'b0;
         if (restart && i == 1) begin
            start = 1'b1;
            @(posedge prog_clk); #1;
            start = 1'b0;
         end
      end
      t = 0;
      while (done_tot == base_dn && t < 200) begin
         @(negedge prog_clk); #1;
         t++;
      end
      check_eq("done_seen", done_tot - base_dn, 1);
      check_eq("done_latency", done_cyc - start_cyc, exp_lat);
      check_eq("shift_count", shift_tot - base_sh, CHAIN_LEN);
      check_eq("sb_empty", exp_q.size(), 0);
      check_eq("chain_contents", chain_m, FULL_STREAM[55:6]);
      check_eq("chain_tail_bits", chain_m[1:0], 2'b11);
      repeat (5) @(posedge prog_clk);
      #1;
      check_eq("single_done", done_tot - base_dn, 1);
      check_eq("idle_after_done", {cfg_ready, ccff_shift_en, busy}, 3'b000);
   endtask

   task automatic reset_mid_load();
      int base_sh, pushed, t;
      base_sh = shift_tot;
      pushed  = 0;
      @(posedge prog_clk); #1;
      start = 1'b1;
      @(posedge prog_clk); #1;
      start     = 1'b0;
      cfg_data  = 8'h5A;
      cfg_valid = 1'b1;
      for (int k = 0; k < 3; k++) push_word(8'h5A, pushed);
      t = 0;
      while ((shift_tot - base_sh) < 20 && t < 100) begin
         @(negedge prog_clk); #1;
         t++;
      end
      check_eq("shifted_20", shift_tot - base_sh, 20);
      prog_reset = 1'b1;
      #1;
      check_eq("reset_outputs", {cfg_ready, ccff_shift_en, ccff_head, busy, done}, 5'b0);
      cfg_valid = 1'b0;
      exp_q.delete();
      @(posedge prog_clk); #1;
      prog_reset = 1'b0;
      base_sh = shift_tot;
      repeat (3) @(posedge prog_clk);
      #1;
      check_eq("no_shift_after_reset", shift_tot - base_sh, 0);
      run_load(-1, 0, 1'b0, 58);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      prog_reset = 1'b1;
      start      = 1'b0;
      cfg_data   = '0;
      cfg_valid  = 1'b0;
      ccff_tail  = 1'b0;
      #2;
      check_eq("reset_state", {cfg_ready, ccff_shift_en, ccff_head, busy, done}, 5'b0);
      repeat (3) @(posedge prog_clk);
      #1;
      prog_reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge prog_clk);
         check_eq("idle_outputs", {cfg_ready, ccff_shift_en, busy, done}, 4'b0000);
      end
      run_load(-1, 0, 1'b0, 58);
      run_load(3, 5, 1'b0, 63);
      run_load(-1, 0, 1'b1, 58);
      reset_mid_load();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Writer end of the configuration-chain protocol used by the connection and switch blocks.
- Accepts configuration words over a valid/ready stream and serialises them MSB-first onto `ccff_head` of a chain of `CHAIN_LEN` flops.
- Drives `ccff_shift_en`, which gates `prog_clk` to the chain through the integration-level ICG. The chain therefore advances only on cycles carrying a real bit; stream stalls never inject junk bits.
- Sits between the configuration port (test/scan interface) and the first `ccff_head` of the fabric.

Parameters:
- CHAIN_LEN, 50, total configuration bits in the downstream chain (e.g. 10 muxes x 5 SRAM bits).
- WORD_W, 8, width of each input configuration word.
- CNT_W, 16, width of the bit counter; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- prog_clk  input  1  configuration clock, rising edge.
- prog_reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load when IDLE.
- cfg_data  input  WORD_W  configuration word; bit WORD_W-1 is shifted first.
- cfg_valid  input  1  cfg_data valid.
- cfg_ready  output  1  loader accepts cfg_data this cycle.
- ccff_head  output  1  serial bit into the chain head.
- ccff_shift_en  output  1  chain clock enable; chain captures ccff_head on this edge.
- ccff_tail  input  1  chain tail (used only with CCFF_READBACK_EN).
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse after the last bit is shifted.

Behaviour:
- Reset values (async assert; release synchronous to prog_clk): state=IDLE, and cfg_ready, ccff_head, ccff_shift_en, busy, done all 0. bit_cnt=0, shreg=0, shreg_left=0.
- State IDLE:
  - start=1 -> LOAD; busy=1 from the next cycle; bit_cnt cleared to 0.
  - start is ignored in every other state.
- State LOAD:
  - cfg_ready=1, ccff_shift_en=0.
  - On cfg_valid && cfg_ready:
    - shreg <= cfg_data.
    - shreg_left <= min(WORD_W, CHAIN_LEN-bit_cnt).
    - next state SHIFT.
- State SHIFT:
  - cfg_ready=0, ccff_shift_en=1, ccff_head=shreg[WORD_W-1] (combinational from shreg).
  - Each cycle: shreg <= shreg<<1, shreg_left--, bit_cnt++.
  - When shreg_left reaches 1 on this cycle:
    - bit_cnt+1 == CHAIN_LEN -> DONE.
    - otherwise -> LOAD.
- State DONE: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
- Latency: each word costs 1 accept cycle + up to WORD_W shift cycles; no back-to-back prefetch.
- Minimum load time from start: 1 + ceil(CHAIN_LEN/WORD_W) + CHAIN_LEN + 1 cycles.
- Partial last word: only the (CHAIN_LEN mod WORD_W) MSBs are shifted; the remaining LSBs are discarded.
- Stream stall (cfg_valid=0 in LOAD): wait indefinitely with ccff_shift_en=0; chain contents unchanged.
- Exactly CHAIN_LEN cycles with ccff_shift_en=1 per load, regardless of stalls.
- ccff_head=0 whenever ccff_shift_en=0.
- Reset mid-load: immediate return to IDLE and ccff_shift_en=0. Chain holds a partial shift; a full reload is required.

Optional Feature:
- Macro: CCFF_READBACK_EN.
- Defined: adds outputs rb_data[WORD_W-1:0] and rb_valid.
  - On every edge with ccff_shift_en=1, ccff_tail is shifted LSB-in into rb_shreg, i.e. the previous chain contents, oldest bit first.
  - rb_valid pulses for one cycle with rb_data=rb_shreg on every WORD_W-th captured bit.
  - At the final bit of the load, any partial word is emitted left-aligned and zero-padded.
  - rb_data/rb_valid reset to 0.
  - No backpressure; the consumer must always accept.
- Undefined: ccff_tail is unused, and no rb_* ports or readback logic exist.

Test Plan:
- Reset then idle 10 cycles -> cfg_ready=0, ccff_shift_en=0, busy=0, done=0 throughout.
- CHAIN_LEN=50, WORD_W=8; start, then 7 words 0xA5,0x3C,0xFF,0x00,0x81,0x7E,0xC0 with cfg_valid always high:
  - exactly 50 ccff_shift_en cycles.
  - bit sequence is the MSB-first concatenation of the words, ending with "11" from 0xC0.
  - done pulses at cycle 58 after start.
  - a 50-flop chain model matches.
- Same load with cfg_valid dropped for 5 cycles before word 3 -> shift_en low during the stall, bit stream identical, done delayed by 5 cycles.
- start pulsed again during SHIFT -> ignored; shift-enable count stays 50; exactly one done.
- prog_reset asserted after 20 shifted bits -> outputs 0 immediately; new start with full load gives the correct final chain contents.
- With CCFF_READBACK_EN: preload chain with a known pattern, then load all-0 -> seven rb_valid pulses; rb_data reproduces the preload oldest-first, and the last word holds 2 bits left-aligned.
